srl_fifo_ctrl: RTL and testbench
================================

Name: srl_fifo_ctrl

Overview:
- Parametrised shift-register FIFO for HLS-style stream and start-token channels between dataflow processes.
- Successor to the fixed SRL primitive: same shift-on-write storage and read-by-address, plus occupancy tracking and full/empty handshake.
- Adds almost-full/almost-empty flags, occupancy output, a synchronous flush, and a sticky peak-occupancy monitor for depth tuning.
- Maps to SRL LUTs: storage has no reset; only control state is reset.

Parameters:
- DATA_WIDTH, 32, payload bits per entry (>=1).
- ADDR_WIDTH, 4, storage index width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 16, entry capacity (>=2).
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  space available; a write is accepted only when if_write && if_full_n.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head-of-queue data, valid whenever if_empty_n=1.
- if_empty_n  out  1  data available; a read is accepted only when if_read && if_empty_n.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy (count).
- if_almost_full  out  1  count >= AF_LEVEL.
- if_almost_empty  out  1  count <= AE_LEVEL.
- flush  in  1  synchronous discard of all entries.
- peak_count  out  ADDR_WIDTH+1  maximum count since reset or peak_clr.
- peak_clr  in  1  synchronous clear of peak_count.

Behaviour:
- Definitions: wr_acc = if_write & if_full_n; rd_acc = if_read & if_empty_n.
- Storage: array of DEPTH entries with no reset. On wr_acc, every entry shifts up one (entry i+1 <= entry i) and entry 0 <= if_din.
- Read path: combinational, if_dout = entry[addr]. addr = count-1 when count>0, else 0.
- Control register count, 0..DEPTH:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - both: unchanged; shift occurs and head index stays correct.
  - neither: hold.
- Flags are registered alongside count, i.e. derived from next-count. They update the cycle after the causing edge, with no combinational path from if_write/if_read:
  - if_full_n = (count != DEPTH).
  - if_empty_n = (count != 0).
  - if_almost_full, if_almost_empty per thresholds.
- Latency: data written at edge N is readable at if_dout with if_empty_n=1 after edge N (1-cycle write-to-read).
- Boundaries:
  - Full with if_write=1 and if_read=0: write ignored, storage and count unchanged.
  - Full with read and write both asserted: only the read is accepted (full_n=0); count -> DEPTH-1.
  - Empty with read and write both asserted: only the write is accepted; count -> 1.
  - Read while empty: ignored, no underflow.
  - count never exceeds DEPTH and never goes below 0.
- flush=1: count <= 0 and flags go to the empty state next cycle. Any wr_acc or rd_acc in the same cycle is discarded (flush has priority). Storage is not cleared.
- peak_count <= max(peak_count, next_count) every cycle.
  - peak_clr=1: peak_count <= next_count.
  - Flush does not clear peak_count.
- Reset (ap_rst_n=0 at an edge): count=0, if_full_n=1, if_empty_n=0, if_almost_full=(AF_LEVEL==0 ? 1 : 0) (always 0 for legal values), if_almost_empty=1, peak_count=0.
  - Reset mid-transfer drops all contents.
  - Accepts during the reset cycle are ignored.
  - if_dout is don't-care after reset.

Decomposition:
- Shared package: occupancy width function clog2(DEPTH+1), and parameter-legality checks (DEPTH>=2, 2**ADDR_WIDTH>=DEPTH, threshold ranges) as elaboration-time assertions.
- One sub-module, srl_fifo_storage: the reset-less shift array with we/addr/din/dout.
- srl_fifo_ctrl holds the count, flags, flush and peak logic.

Test Plan:
- Reset then fill: write 0x11..0x20 (16 words) back-to-back.
  - if_full_n drops after the 16th accept.
  - if_almost_full rises when count reaches 14.
  - A 17th write attempt is ignored and num_data_valid stays 16.
- Drain order: read all 16 entries.
  - if_dout sequence is 0x11..0x20.
  - if_empty_n falls after the last read; an extra read leaves count at 0.
- Simultaneous read/write at count=5: hold both asserted for 10 cycles.
  - count stays 5; output order is strict FIFO.
  - At count=0, simultaneous read and write -> count 1, data visible next cycle.
- Full with read and write both asserted: count 16 -> 15, head advances, write data is not stored.
- Flush at count=9 with if_write=1 in the same cycle: next cycle count=0, empty_n=0, full_n=1, peak_count=9.
  - A subsequent write of 0xAB reads back as 0xAB.
- Reset mid-stream at count=7 with peak 12:
  - All outputs return to reset values and peak_count=0.
  - peak_clr with count=3 sets peak_count=3.

Source files
------------

// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the shift-register FIFO.
// Parameter legality is checked here so every instantiating file applies the same rules.
package srl_fifo_ctrl_pkg;

    typedef struct packed {
        logic full_n;
        logic empty_n;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Bits needed to hold an occupancy from 0 to depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int data_width, input int addr_width,
                                        input int depth, input int af_level,
                                        input int ae_level);
        return (data_width >= 1) && (depth >= 2) && ((2 ** addr_width) >= depth) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1) &&
               (occ_width(depth) <= addr_width + 1);
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Stream port of the FIFO: producer write side, consumer read side and status.
// Handshake: a word moves on a rising edge only when if_write && if_full_n (write) or
// if_read && if_empty_n (read); full_n/empty_n are registered and never depend on the requests.
interface srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic                  if_almost_full;
    logic                  if_almost_empty;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid,
               if_almost_full, if_almost_empty
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid,
               if_almost_full, if_almost_empty
    );
endinterface

// File: rtl/srl_fifo_ctrl_storage.sv
// Reset-less shift array: a write pushes every entry up one slot and lands at entry 0.
// Reads are combinational by index so the array maps onto SRL primitives.
module srl_fifo_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];
endmodule

// File: rtl/srl_fifo_ctrl.sv
// Occupancy, flag, flush and peak-occupancy control around the SRL shift array.
// Flags are registered from the next count so no request path reaches them combinationally.
module srl_fifo_ctrl
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    srl_fifo_ctrl_if.slave      fifo,
    input  logic                flush,
    input  logic                peak_clr,
    output logic [ADDR_WIDTH:0] peak_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    if (!params_legal(DATA_WIDTH, ADDR_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("srl_fifo_ctrl: illegal parameter combination");
    end

    function automatic fifo_flags_t flags_for(input logic [CW-1:0] cnt);
        fifo_flags_t f;
        f.full_n       = (cnt != DEPTH_C);
        f.empty_n      = (cnt != '0);
        f.almost_full  = (cnt >= AF_C);
        f.almost_empty = (cnt <= AE_C);
        return f;
    endfunction

    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         peak_q, peak_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_acc = fifo.if_write & flags_q.full_n;
    assign rd_acc = fifo.if_read  & flags_q.empty_n;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - ONE_C;
        end
    end

    always_comb begin
        flags_d = flags_for(count_d);
        peak_d  = peak_q;
        if (peak_clr || (count_d > peak_q)) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            count_q <= '0;
            flags_q <= flags_for('0);
            peak_q  <= '0;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
            peak_q  <= peak_d;
        end
    end

    // Head sits at count-1; a simultaneous read+write shifts and pops, so the index holds.
    always_comb begin
        rd_addr = '0;
        if (count_q != '0) begin
            rd_addr = ADDR_WIDTH'(count_q - ONE_C);
        end
    end

    srl_fifo_storage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_storage (
        .clk (ap_clk),
        .we  (wr_acc & ~flush),
        .addr(rd_addr),
        .din (fifo.if_din),
        .dout(fifo.if_dout)
    );

    assign fifo.if_full_n         = flags_q.full_n;
    assign fifo.if_empty_n        = flags_q.empty_n;
    assign fifo.if_almost_full    = flags_q.almost_full;
    assign fifo.if_almost_empty   = flags_q.almost_empty;
    assign fifo.if_num_data_valid = count_q;
    assign peak_count             = peak_q;
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl: fill/drain, simultaneous traffic, boundaries, flush, reset, peak.
// A queue model tracks contents and peak; hand-computed constants pin the key boundary points.
module tb_srl_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          flush;
    logic          peak_clr;
    logic [AW:0]   peak_count;

    srl_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    srl_fifo_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .fifo      (bus.slave),
        .flush     (flush),
        .peak_clr  (peak_clr),
        .peak_count(peak_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [DW-1:0] exp_q[$];
    int            m_peak;
    int            n_pass;
    int            n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ":count"},   32'(bus.if_num_data_valid), 32'(n));
        chk({tag, ":full_n"},  32'(bus.if_full_n),         32'(n != DEPTH));
        chk({tag, ":empty_n"}, 32'(bus.if_empty_n),        32'(n != 0));
        chk({tag, ":afull"},   32'(bus.if_almost_full),    32'(n >= AF));
        chk({tag, ":aempty"},  32'(bus.if_almost_empty),   32'(n <= AE));
        chk({tag, ":peak"},    32'(peak_count),            32'(m_peak));
        if (n > 0) chk({tag, ":dout"}, bus.if_dout, exp_q[0]);
    endtask

    // One clock with the given requests; inputs change 1 time unit after the edge.
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                         input logic r, input logic f, input logic pc);
        bit wa, ra;
        int n;
        wa = w && (exp_q.size() != DEPTH);
        ra = r && (exp_q.size() != 0);
        bus.if_write = w;
        bus.if_din   = d;
        bus.if_read  = r;
        flush        = f;
        peak_clr     = pc;
        @(posedge ap_clk);
        #1;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        flush        = 1'b0;
        peak_clr     = 1'b0;
        if (f) begin
            exp_q.delete();
        end else begin
            if (ra) void'(exp_q.pop_front());
            if (wa) exp_q.push_back(d);
        end
        n = exp_q.size();
        if (pc || n > m_peak) m_peak = n;
        check_model(tag);
    endtask

    task automatic do_reset(input logic w);
        ap_rst_n     = 1'b0;
        bus.if_write = w;
        bus.if_din   = 32'hDEAD_BEEF;
        bus.if_read  = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        exp_q.delete();
        m_peak = 0;
        chk("rst:count",   32'(bus.if_num_data_valid), 32'd0);
        chk("rst:full_n",  32'(bus.if_full_n),         32'd1);
        chk("rst:empty_n", 32'(bus.if_empty_n),        32'd0);
        chk("rst:afull",   32'(bus.if_almost_full),    32'd0);
        chk("rst:aempty",  32'(bus.if_almost_empty),   32'd1);
        chk("rst:peak",    32'(peak_count),            32'd0);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        m_peak = 0;
        ap_rst_n = 1'b0;
        flush = 1'b0;
        peak_clr = 1'b0;
        bus.if_write = 1'b0;
        bus.if_read = 1'b0;
        bus.if_din = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        do_reset(1'b1);

        // Fill with 0x11..0x20
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 32'(8'h11 + i), 1'b0, 1'b0, 1'b0);
            if (i == 12) chk("fill13:afull", 32'(bus.if_almost_full), 32'd0);
            if (i == 13) chk("fill14:afull", 32'(bus.if_almost_full), 32'd1);
        end
        chk("full:full_n", 32'(bus.if_full_n), 32'd0);
        chk("full:head",   bus.if_dout,        32'h11);
        cycle("wr_full", 1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        chk("wr_full:count", 32'(bus.if_num_data_valid), 32'd16);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain:dout", bus.if_dout, 32'(8'h11 + i));
            cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("empty:empty_n", 32'(bus.if_empty_n), 32'd0);
        cycle("rd_empty", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rd_empty:count", 32'(bus.if_num_data_valid), 32'd0);
        chk("peak16", 32'(peak_count), 32'd16);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 32'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle("rw5", 1'b1, 32'(8'h40 + k), 1'b1, 1'b0, 1'b0);
            chk("rw5:count", 32'(bus.if_num_data_valid), 32'd5);
        end
        chk("rw5:head", bus.if_dout, 32'h45);
        for (int i = 0; i < 5; i++) cycle("post5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Read+write at empty: only the write lands
        cycle("rw0", 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("rw0:count", 32'(bus.if_num_data_valid), 32'd1);
        chk("rw0:dout",  bus.if_dout,                32'h55);
        cycle("rw0_out", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Read+write at full: only the read lands
        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 32'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle("rwfull", 1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
        chk("rwfull:count", 32'(bus.if_num_data_valid), 32'd15);
        chk("rwfull:dout",  bus.if_dout,                32'h61);
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk("rwfull_drain:dout", bus.if_dout, 32'(8'h61 + i));
            cycle("rwfull_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("rwfull_drain:empty_n", 32'(bus.if_empty_n), 32'd0);

        // Flush at count 9 with a concurrent write
        cycle("pclr0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("pclr0:peak", 32'(peak_count), 32'd0);
        for (int i = 0; i < 9; i++) cycle("pre_flush", 1'b1, 32'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'hCC, 1'b0, 1'b1, 1'b0);
        chk("flush:count",   32'(bus.if_num_data_valid), 32'd0);
        chk("flush:empty_n", 32'(bus.if_empty_n),        32'd0);
        chk("flush:full_n",  32'(bus.if_full_n),         32'd1);
        chk("flush:peak",    32'(peak_count),            32'd9);
        cycle("post_flush", 1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);
        chk("post_flush:dout", bus.if_dout, 32'hAB);
        cycle("post_flush_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream at count 7 with peak 12
        cycle("pclr1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle("pre_rst", 1'b1, 32'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("pre_rst_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst:count", 32'(bus.if_num_data_valid), 32'd7);
        chk("pre_rst:peak",  32'(peak_count),            32'd12);
        do_reset(1'b1);

        // peak_clr loads the current count
        for (int i = 0; i < 5; i++) cycle("pk_wr", 1'b1, 32'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle("pk_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pk:peak5", 32'(peak_count), 32'd5);
        cycle("pk_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("pk_clr:peak", 32'(peak_count), 32'd3);
        chk("pk_clr:dout", bus.if_dout,     32'h92);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
